// File: rtl/inst_fetch_buf.sv
// rtl/inst_fetch_buf.sv - instruction fetch stage with prefetch FIFO and redirect
// Optional same-cycle bypass from mem_rdata to decode under FETCH_BYPASS_EN.
module inst_fetch_buf #(
    parameter int          ADDR_WIDTH = 10,
    parameter logic [31:0] RESET_PC   = 32'h0,
    parameter int          DEPTH      = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic [ADDR_WIDTH-1:0] mem_raddr,
    output logic                  mem_rden,
    input  logic [31:0]           mem_rdata,
    output logic                  inst_valid,
    input  logic                  inst_ready,
    output logic [31:0]           inst,
    output logic [31:0]           inst_pc,
    input  logic                  redirect,
    input  logic [31:0]           redirect_pc
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [31:0] fpc_q, fpc_d;
    logic [PW-1:0] head_q, head_d, tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic [63:0] fifo_q [DEPTH];
    logic [63:0] fifo_d [DEPTH];

    logic not_full, empty, fetch, pop, push, fifo_pop;
    logic [63:0] head_word;
    logic [1:0] unused_rpc_low;

    assign unused_rpc_low = redirect_pc[1:0];

    // A full FIFO always presents a valid head, so "pop" reduces to inst_ready
    // there; this keeps fetch independent of inst_valid and avoids a loop.
    always_comb begin
        not_full  = (count_q != FULL);
        empty     = (count_q == '0);
        fetch     = rst_n & ~redirect & (not_full | inst_ready);
        head_word = fifo_q[head_q];
`ifdef FETCH_BYPASS_EN
        inst_valid = ~empty | fetch;
        if (!empty) begin
            inst    = head_word[31:0];
            inst_pc = head_word[63:32];
        end else if (fetch) begin
            inst    = mem_rdata;
            inst_pc = fpc_q;
        end else begin
            inst    = '0;
            inst_pc = '0;
        end
        pop  = inst_valid & inst_ready;
        push = fetch & ~(empty & inst_ready);
`else
        inst_valid = ~empty;
        inst       = empty ? 32'h0 : head_word[31:0];
        inst_pc    = empty ? 32'h0 : head_word[63:32];
        pop        = inst_valid & inst_ready;
        push       = fetch;
`endif
        fifo_pop  = pop & ~empty;
        mem_rden  = fetch;
        mem_raddr = fpc_q[ADDR_WIDTH+1:2];
    end

    always_comb begin
        fifo_d = fifo_q;
        if (push) begin
            fifo_d[tail_q] = {fpc_q, mem_rdata};
        end
        if (redirect) begin
            fpc_d   = {redirect_pc[31:2], 2'b00};
            count_d = '0;
            head_d  = '0;
            tail_d  = '0;
        end else begin
            fpc_d   = fetch ? fpc_q + 32'd4 : fpc_q;
            count_d = count_q + CW'(push) - CW'(fifo_pop);
            head_d  = head_q + PW'(fifo_pop);
            tail_d  = tail_q + PW'(push);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fpc_q   <= {RESET_PC[31:2], 2'b00};
            count_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            fpc_q   <= fpc_d;
            count_q <= count_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            fifo_q  <= fifo_d;
        end
    end

endmodule

// File: tb/tb_inst_fetch_buf.sv
// tb/tb_inst_fetch_buf.sv - directed self-checking bench for inst_fetch_buf
module tb_inst_fetch_buf;

    logic        clk;
    logic        rst_n;
    logic [9:0]  mem_raddr;
    logic        mem_rden;
    logic [31:0] mem_rdata;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        redirect;
    logic [31:0] redirect_pc;

    logic [31:0] mem [0:1023];
    logic [31:0] stream_words [4];
    int total;
    int bad;

    inst_fetch_buf #(.ADDR_WIDTH(10), .RESET_PC(32'h0), .DEPTH(2)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .mem_raddr(mem_raddr),
        .mem_rden(mem_rden),
        .mem_rdata(mem_rdata),
        .inst_valid(inst_valid),
        .inst_ready(inst_ready),
        .inst(inst),
        .inst_pc(inst_pc),
        .redirect(redirect),
        .redirect_pc(redirect_pc)
    );

    assign mem_rdata = mem[mem_raddr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        for (int i = 0; i < 1024; i++) begin
            mem[i] = 32'hA000_0000 | i;
        end
        mem[0] = 32'h241a0001;
        mem[1] = 32'h17400002;
        mem[2] = 32'h0;
        mem[3] = 32'hffffffff;
        stream_words[0] = 32'h241a0001;
        stream_words[1] = 32'h17400002;
        stream_words[2] = 32'h0;
        stream_words[3] = 32'hffffffff;

        rst_n       = 1'b0;
        inst_ready  = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        repeat (2) tick();
        chk("rst_valid", {31'b0, inst_valid}, 32'd0);
        chk("rst_inst", inst, 32'h0);
        chk("rst_pc", inst_pc, 32'h0);
        chk("rst_rden", {31'b0, mem_rden}, 32'd0);
        chk("rst_raddr", {22'b0, mem_raddr}, 32'h0);

        // stream from RESET_PC with decode always ready
        #2;
        rst_n      = 1'b1;
        inst_ready = 1'b1;
        #1;
        chk("pre_rden", {31'b0, mem_rden}, 32'd1);
        chk("pre_valid", {31'b0, inst_valid}, 32'd0);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("str_valid", {31'b0, inst_valid}, 32'd1);
            chk("str_pc", inst_pc, 32'(4 * k));
            chk("str_inst", inst, stream_words[k]);
        end

        // asynchronous reset between edges
        rst_n = 1'b0;
        #1;
        chk("ar_valid", {31'b0, inst_valid}, 32'd0);
        chk("ar_inst", inst, 32'h0);
        chk("ar_pc", inst_pc, 32'h0);
        chk("ar_rden", {31'b0, mem_rden}, 32'd0);
        inst_ready = 1'b0;
        #1;
        rst_n = 1'b1;

        // backpressure: fills after two pushes then holds
        tick();
        chk("bp_first_pc", inst_pc, 32'h0);
        chk("bp_first_rden", {31'b0, mem_rden}, 32'd1);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("bp_rden", {31'b0, mem_rden}, 32'd0);
            chk("bp_raddr", {22'b0, mem_raddr}, 32'd2);
            chk("bp_inst", inst, 32'h241a0001);
            chk("bp_pc", inst_pc, 32'h0);
        end
        inst_ready = 1'b1;
        #1;
        chk("rel_rden", {31'b0, mem_rden}, 32'd1);
        chk("rel_pc0", inst_pc, 32'h0);
        tick();
        chk("rel_pc4", inst_pc, 32'h4);
        tick();
        chk("rel_pc8", inst_pc, 32'h8);
        chk("rel_inst8", inst, 32'h0);

        // redirect with two entries buffered, decode stalled
        inst_ready  = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 32'h2b;
        #1;
        chk("rd_rden", {31'b0, mem_rden}, 32'd0);
        tick();
        redirect = 1'b0;
        chk("rd_bubble", {31'b0, inst_valid}, 32'd0);
        chk("rd_raddr", {22'b0, mem_raddr}, 32'd10);
        #1;
        chk("rd_rden2", {31'b0, mem_rden}, 32'd1);
        tick();
        chk("rd_valid", {31'b0, inst_valid}, 32'd1);
        chk("rd_pc", inst_pc, 32'h28);
        chk("rd_inst", inst, 32'hA000_000A);
        tick();
        chk("rd_hold_pc", inst_pc, 32'h28);
        chk("rd_full_rden", {31'b0, mem_rden}, 32'd0);

        // redirect coincident with a pop at full FIFO
        inst_ready  = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h40;
        #1;
        chk("rp_pop_valid", {31'b0, inst_valid}, 32'd1);
        chk("rp_pop_pc", inst_pc, 32'h28);
        tick();
        redirect = 1'b0;
        chk("rp_bubble", {31'b0, inst_valid}, 32'd0);
        chk("rp_raddr", {22'b0, mem_raddr}, 32'h10);
        tick();
        chk("rp_pc", inst_pc, 32'h40);
        chk("rp_inst", inst, 32'hA000_0010);
        tick();
        chk("rp_next_pc", inst_pc, 32'h44);

        // memory index wrap
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0FFC;
        tick();
        redirect = 1'b0;
        chk("wr_raddr_top", {22'b0, mem_raddr}, 32'h3FF);
        chk("wr_bubble", {31'b0, inst_valid}, 32'd0);
        tick();
        chk("wr_raddr_zero", {22'b0, mem_raddr}, 32'h0);
        chk("wr_pc_ffc", inst_pc, 32'hFFC);
        chk("wr_inst_ffc", inst, 32'hA000_03FF);
        tick();
        chk("wr_pc_1000", inst_pc, 32'h1000);
        chk("wr_inst_1000", inst, 32'h241a0001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
